systolic_sequencer: RTL and testbench

//  Start/done controller for the 2x2 systolic convolution datapath (4x4 input, 3x3 filter).

---
 rtl/systolic_sequencer.sv | 151 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Start/done controller for the 2x2 systolic convolution datapath.
// Walks CLEAR -> FEED -> DRAIN -> DONE once per start; every output is a registered enable.
module systolic_sequencer #(
  parameter int FEED_STEPS   = 13,
  parameter int DRAIN_CYCLES = 2,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] seq_idx,
  output logic             feed_valid,
  output logic             pe_en,
  output logic             pe_clr,
  output logic             pe_mode,
  output logic             mem_shift,
  output logic [7:0]       op_count,
  output logic [2:0]       dbg_state_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
  localparam int CNT_W   = (IDX_W > DRAIN_W) ? IDX_W : DRAIN_W;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_STEPS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   seq_idx_q, seq_idx_d;
  logic               feed_valid_q, feed_valid_d;
  logic               pe_en_q, pe_en_d;
  logic               pe_clr_q, pe_clr_d;
  logic               pe_mode_q, pe_mode_d;
  logic               mem_shift_q, mem_shift_d;
  logic [7:0]         op_count_q, op_count_d;

  // Next-state logic; abort in a running state returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_CLEAR;
      S_CLEAR: state_d = abort ? S_IDLE : S_FEED;
      S_FEED: begin
        if (abort)                    state_d = S_IDLE;
        else if (step_q == FEED_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                     state_d = S_IDLE;
        else if (step_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Step counter restarts on every state entry and only advances in FEED/DRAIN.
  always_comb begin
    step_d = step_q + 1'b1;
    if (state_d != state_q || (state_d != S_FEED && state_d != S_DRAIN)) begin
      step_d = '0;
    end
  end

  // Moore outputs decoded from the upcoming state, then registered.
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    seq_idx_d    = '1;
    feed_valid_d = 1'b0;
    pe_en_d      = 1'b0;
    pe_clr_d     = 1'b0;
    pe_mode_d    = 1'b0;
    mem_shift_d  = 1'b0;
    op_count_d   = op_count_q;
    unique case (state_d)
      S_CLEAR: begin
        busy_d   = 1'b1;
        pe_clr_d = 1'b1;
      end
      S_FEED: begin
        busy_d       = 1'b1;
        feed_valid_d = 1'b1;
        pe_en_d      = 1'b1;
        seq_idx_d    = IDX_W'(step_d);
      end
      S_DRAIN: begin
        busy_d      = 1'b1;
        pe_en_d     = 1'b1;
        pe_mode_d   = 1'b1;
        mem_shift_d = 1'b1;
      end
      S_DONE: begin
        done_d     = 1'b1;
        op_count_d = op_count_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seq_idx_q    <= '1;
      feed_valid_q <= 1'b0;
      pe_en_q      <= 1'b0;
      pe_clr_q     <= 1'b0;
      pe_mode_q    <= 1'b0;
      mem_shift_q  <= 1'b0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seq_idx_q    <= seq_idx_d;
      feed_valid_q <= feed_valid_d;
      pe_en_q      <= pe_en_d;
      pe_clr_q     <= pe_clr_d;
      pe_mode_q    <= pe_mode_d;
      mem_shift_q  <= mem_shift_d;
      op_count_q   <= op_count_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign seq_idx     = seq_idx_q;
  assign feed_valid  = feed_valid_q;
  assign pe_en       = pe_en_q;
  assign pe_clr      = pe_clr_q;
  assign pe_mode     = pe_mode_q;
  assign mem_shift   = mem_shift_q;
  assign op_count    = op_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: reset, full run timeline, ignored start,
// back-to-back runs, abort, reset mid-run, op_count wrap and abort+start in IDLE.
module tb_systolic_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] seq_idx;
  logic       feed_valid;
  logic       pe_en;
  logic       pe_clr;
  logic       pe_mode;
  logic       mem_shift;
  logic [7:0] op_count;
  logic [2:0] dbg_state;

  int checks;
  int failures;

  systolic_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .seq_idx     (seq_idx),
    .feed_valid  (feed_valid),
    .pe_en       (pe_en),
    .pe_clr      (pe_clr),
    .pe_mode     (pe_mode),
    .mem_shift   (mem_shift),
    .op_count    (op_count),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle/reset output values with a given op_count.
  task automatic check_idle(input string tag, input logic [7:0] exp_cnt);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
    check({tag, ".seq_idx"},    32'(seq_idx),    32'hF);
    check({tag, ".feed_valid"}, 32'(feed_valid), 32'd0);
    check({tag, ".pe_en"},      32'(pe_en),      32'd0);
    check({tag, ".pe_clr"},     32'(pe_clr),     32'd0);
    check({tag, ".pe_mode"},    32'(pe_mode),    32'd0);
    check({tag, ".mem_shift"},  32'(mem_shift),  32'd0);
    check({tag, ".op_count"},   32'(op_count),   32'(exp_cnt));
    check({tag, ".state"},      32'(dbg_state),  32'd0);
  endtask

  task automatic check_clear(input string tag);
    check({tag, ".clr.busy"},   32'(busy),       32'd1);
    check({tag, ".clr.pe_clr"}, 32'(pe_clr),     32'd1);
    check({tag, ".clr.pe_en"},  32'(pe_en),      32'd0);
    check({tag, ".clr.fv"},     32'(feed_valid), 32'd0);
    check({tag, ".clr.idx"},    32'(seq_idx),    32'hF);
  endtask

  task automatic check_feed(input string tag, input int idx);
    check({tag, ".feed.idx"},    32'(seq_idx),    32'(idx));
    check({tag, ".feed.fv"},     32'(feed_valid), 32'd1);
    check({tag, ".feed.pe_en"},  32'(pe_en),      32'd1);
    check({tag, ".feed.mode"},   32'(pe_mode),    32'd0);
    check({tag, ".feed.busy"},   32'(busy),       32'd1);
    check({tag, ".feed.pe_clr"}, 32'(pe_clr),     32'd0);
    check({tag, ".feed.shift"},  32'(mem_shift),  32'd0);
  endtask

  task automatic check_drain(input string tag);
    check({tag, ".drn.mode"},  32'(pe_mode),    32'd1);
    check({tag, ".drn.shift"}, 32'(mem_shift),  32'd1);
    check({tag, ".drn.pe_en"}, 32'(pe_en),      32'd1);
    check({tag, ".drn.fv"},    32'(feed_valid), 32'd0);
    check({tag, ".drn.idx"},   32'(seq_idx),    32'hF);
    check({tag, ".drn.busy"},  32'(busy),       32'd1);
    check({tag, ".drn.done"},  32'(done),       32'd0);
  endtask

  // Full 13/2 timeline from a start pulse, ending back in IDLE.
  task automatic full_run(input string tag, input logic [7:0] cnt_before);
    logic [7:0] cnt_after;
    cnt_after = cnt_before + 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_clear(tag);
    for (int i = 0; i < 13; i++) begin
      tick();
      check_feed(tag, i);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check_drain(tag);
    end
    tick();
    check({tag, ".done"},     32'(done),      32'd1);
    check({tag, ".done.busy"},32'(busy),      32'd0);
    check({tag, ".done.en"},  32'(pe_en),     32'd0);
    check({tag, ".done.cnt"}, 32'(op_count),  32'(cnt_after));
    tick();
    check_idle({tag, ".end"}, cnt_after);
  endtask

  initial begin
    int n_done;
    logic [7:0] exp_cnt;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;

    // 1. Reset for two cycles, then idle.
    tick();
    tick();
    check_idle("rst", 8'd0);
    rst = 1'b0;
    tick();
    check_idle("post_rst", 8'd0);

    // 2. Single run.
    full_run("run1", 8'd0);

    // 3a. start re-pulsed in FEED at idx 6 is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("repulse.idx6", 32'(seq_idx), 32'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
    end
    check("repulse.ndone", 32'(n_done), 32'd1);
    check_idle("repulse.end", 8'd2);

    // 3b. start held high: done at T+17, T+35, T+53.
    exp_cnt = 8'd2;
    start = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      tick();
      if (k == 17 || k == 35 || k == 53) begin
        exp_cnt = exp_cnt + 8'd1;
        check("b2b.done", 32'(done), 32'd1);
        check("b2b.cnt", 32'(op_count), 32'(exp_cnt));
      end else begin
        check("b2b.nodone", 32'(done), 32'd0);
      end
      if (k == 1 || k == 19 || k == 37) check("b2b.clr", 32'(pe_clr), 32'd1);
    end
    start = 1'b0;
    tick();
    check_idle("b2b.end", 8'd5);

    // 4. abort at seq_idx 5, then a clean run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort.idx5", 32'(seq_idx), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort", 8'd5);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort.ndone", 32'(n_done), 32'd0);
    full_run("after_abort", 8'd5);

    // 5. Reset during DRAIN.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_drain("rst_drain");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_drain", 8'd0);
    tick();
    check_idle("rst_drain.post", 8'd0);

    // 6. 256 runs wrap op_count 255 -> 0.
    n_done  = 0;
    exp_cnt = 8'd0;
    start   = 1'b1;
    for (int c = 0; c < 256 * 18 + 100 && n_done < 256; c++) begin
      tick();
      if (done) begin
        n_done++;
        exp_cnt = exp_cnt + 8'd1;
        check("wrap.cnt", 32'(op_count), 32'(exp_cnt));
        if (n_done == 255) check("wrap.255", 32'(op_count), 32'd255);
      end
    end
    start = 1'b0;
    check("wrap.ndone", 32'(n_done), 32'd256);
    check("wrap.zero", 32'(op_count), 32'd0);
    tick();
    check_idle("wrap.end", 8'd0);

    // abort and start together in IDLE: stays IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    check_idle("abort_start", 8'd0);
    tick();
    check_idle("abort_start2", 8'd0);
    start = 1'b0;
    abort = 1'b0;
    tick();
    check_idle("abort_start3", 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
